// File: rtl/axi_tx.sv
`default_nettype none
// =============================================================================
// Module   : axi_tx
// Brief    : AXI-Stream master transmitter: FWFT word FIFO, packet-boundary
//            transmit gate and packet/byte/keep-error counters.
// Revision : 1.0
// =============================================================================
module axi_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [DATA_WIDTH/8-1:0]      in_keep,
    input  logic                         in_last,
    output logic                         in_ready,
    input  logic                         tx_enable,
    input  logic                         cnt_clr,
    output logic                         tvalid,
    output logic [DATA_WIDTH-1:0]        tdata,
    output logic [DATA_WIDTH/8-1:0]      tkeep,
    output logic                         tlast,
    input  logic                         tready,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [31:0]                  pkt_count,
    output logic [31:0]                  byte_count,
    output logic [15:0]                  keep_err_count
);

    localparam int c_KW = DATA_WIDTH / 8;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH + 1);
    localparam int c_BW = $clog2(c_KW + 1);
    localparam int c_EW = DATA_WIDTH + c_KW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [c_EW-1:0]       r_mem [DEPTH];
    logic [c_AW-1:0]       r_wptr;
    logic [c_AW-1:0]       r_rptr;
    logic [c_LW-1:0]       r_level;
    logic [0:0]            r_state;
    logic                  r_in_pkt;
    logic [31:0]           r_pkt_count;
    logic [31:0]           r_byte_count;
    logic [15:0]           r_keep_err;

    logic                  w_empty;
    logic                  w_tvalid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_keep_bad;
    logic [c_EW-1:0]       w_head;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [c_KW-1:0]       w_head_keep;
    logic                  w_head_last;
    logic [c_BW-1:0]       w_pop_bytes;

    assign w_empty  = (r_level == '0);
    assign w_tvalid = (r_state == c_SEND) && !w_empty;
    assign in_ready = (r_level < c_FULL) && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_tvalid && tready;

    // Head entry is forced to zero when empty so the output bus is quiet.
    assign w_head      = w_empty ? '0 : r_mem[r_rptr];
    assign w_head_last = w_head[0];
    assign w_head_keep = w_head[c_KW:1];
    assign w_head_data = w_head[c_EW-1:c_KW+1];

    assign w_keep_bad = (!in_last && (in_keep != {c_KW{1'b1}})) || (in_keep == '0);

    always_comb begin
        w_pop_bytes = '0;
        for (int i = 0; i < c_KW; i++) begin
            w_pop_bytes = w_pop_bytes + c_BW'(w_head_keep[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_data, in_keep, in_last};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    // Dropping out of SEND only happens at a packet boundary or with nothing in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_in_pkt <= 1'b0;
        end else begin
            if (w_pop) r_in_pkt <= !w_head_last;
            case (r_state)
                c_IDLE: begin
                    if (tx_enable && !w_empty) r_state <= c_SEND;
                end
                c_SEND: begin
                    if (!tx_enable && ((w_pop && w_head_last) || (!w_tvalid && !r_in_pkt)))
                        r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_keep_err   <= '0;
        end else begin
            if (w_pop) begin
                r_byte_count <= r_byte_count + 32'(w_pop_bytes);
                if (w_head_last) r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_push && w_keep_bad && (r_keep_err != 16'hFFFF)) begin
                r_keep_err <= r_keep_err + 1'b1;
            end
        end
    end

    assign tvalid         = w_tvalid;
    assign tdata          = w_head_data;
    assign tkeep          = w_head_keep;
    assign tlast          = w_head_last;
    assign busy           = (r_state == c_SEND) || !w_empty;
    assign fifo_level     = r_level;
    assign pkt_count      = r_pkt_count;
    assign byte_count     = r_byte_count;
    assign keep_err_count = r_keep_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_tx.sv
`default_nettype none
// =============================================================================
// Module   : tb_axi_tx
// Brief    : Directed self-checking bench for axi_tx (DATA_WIDTH=64, DEPTH=4).
// Revision : 1.0
// =============================================================================
module tb_axi_tx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last;
    logic        in_ready;
    logic        tx_enable;
    logic        cnt_clr;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [31:0] pkt_count;
    logic [31:0] byte_count;
    logic [15:0] keep_err_count;

    axi_tx #(.DATA_WIDTH(64), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_ready(in_ready), .tx_enable(tx_enable), .cnt_clr(cnt_clr),
        .tvalid(tvalid), .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tready(tready),
        .busy(busy), .fifo_level(fifo_level), .pkt_count(pkt_count),
        .byte_count(byte_count), .keep_err_count(keep_err_count)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int          c;
    } beat_t;

    beat_t mon_q[$];
    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    push_cyc;
    bit    stab_en = 0;
    bit    prod_done;
    logic        p_v, p_r, p_l;
    logic [63:0] p_d;
    logic [7:0]  p_k;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat recorder plus hold-while-stalled check.
    always @(negedge clk) begin
        if (!rst && tvalid && tready) mon_q.push_back('{d: tdata, k: tkeep, l: tlast, c: cyc});
        if (stab_en && p_v && !p_r) begin
            n_tests++;
            if (tvalid !== 1'b1 || tdata !== p_d || tkeep !== p_k || tlast !== p_l) begin
                n_fail++;
                $display("FAIL stability: got v=%b d=%h k=%h l=%b required v=1 d=%h k=%h l=%b",
                         tvalid, tdata, tkeep, tlast, p_d, p_k, p_l);
            end
        end
        p_v = tvalid; p_r = tready; p_d = tdata; p_k = tkeep; p_l = tlast;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: in_ready got %b required 1", in_ready);
        end
        push_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
        tx_enable = 1'b0; tready = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        n_tests++;
        if ({tvalid, tlast, busy} !== 3'b000 || tdata !== 64'h0 || tkeep !== 8'h0 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b busy=%b d=%h k=%h lvl=%0d required all 0",
                     tvalid, tlast, busy, tdata, tkeep, fifo_level);
        end
        n_tests++;
        if (pkt_count !== 32'd0 || byte_count !== 32'd0 || keep_err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0", pkt_count, byte_count, keep_err_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_single_packet();
        logic [63:0] ed [3];
        logic [7:0]  ek [3];
        int n0;
        ed[0] = 64'hA000_0000_0000_0001; ed[1] = 64'hA000_0000_0000_0002; ed[2] = 64'hA000_0000_0000_0003;
        ek[0] = 8'hFF; ek[1] = 8'hFF; ek[2] = 8'h0F;
        @(posedge clk); #1;
        tx_enable = 1'b1; tready = 1'b1; mon_q.delete();
        push_word(ed[0], ek[0], 1'b0);
        n0 = push_cyc;
        push_word(ed[1], ek[1], 1'b0);
        push_word(ed[2], ek[2], 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mon_q.size() != 3) begin
            n_fail++; $display("FAIL single_beats: got %0d beats required 3", mon_q.size());
        end else begin
            // From IDLE the first beat lands two cycles after the push.
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (mon_q[i].d !== ed[i] || mon_q[i].k !== ek[i] || mon_q[i].l !== (i == 2) || mon_q[i].c != n0 + 2 + i) begin
                    n_fail++;
                    $display("FAIL single_beat%0d: got d=%h k=%h l=%b cyc=%0d required d=%h k=%h l=%b cyc=%0d",
                             i, mon_q[i].d, mon_q[i].k, mon_q[i].l, mon_q[i].c, ed[i], ek[i], (i == 2), n0 + 2 + i);
                end
            end
        end
        n_tests++;
        if (pkt_count !== 32'd1 || byte_count !== 32'd20 || keep_err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL single_counters: got %0d/%0d/%0d required 1/20/0", pkt_count, byte_count, keep_err_count);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        tready = 1'b0; mon_q.delete();
        for (int i = 0; i < 4; i++) push_word(64'hB000_0000_0000_0000 | 64'(i), 8'hFF, 1'b0);
        in_valid = 1'b1; in_data = 64'hB000_0000_0000_0004; in_keep = 8'hFF; in_last = 1'b0;
        @(negedge clk);
        n_tests++;
        if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: got lvl=%0d rdy=%b required lvl=4 rdy=0", fifo_level, in_ready);
        end
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== 64'hB000_0000_0000_0000) begin
            n_fail++; $display("FAIL bp_head: got v=%b d=%h required v=1 d=b000000000000000", tvalid, tdata);
        end
        @(posedge clk); #1;
        tready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_pop_cycle: in_ready got %b required 0", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || fifo_level !== 3'd3) begin
            n_fail++; $display("FAIL bp_after_pop: got rdy=%b lvl=%0d required rdy=1 lvl=3", in_ready, fifo_level);
        end
        @(posedge clk); #1;
        push_word(64'hB000_0000_0000_0005, 8'hFF, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mon_q.size() != 6) begin
            n_fail++; $display("FAIL bp_beats: got %0d beats required 6", mon_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (mon_q[i].d !== (64'hB000_0000_0000_0000 | 64'(i)) || mon_q[i].l !== (i == 5)) begin
                    n_fail++;
                    $display("FAIL bp_order%0d: got d=%h l=%b required d=%h l=%b",
                             i, mon_q[i].d, mon_q[i].l, 64'hB000_0000_0000_0000 | 64'(i), (i == 5));
                end
            end
        end
        n_tests++;
        if (pkt_count !== 32'd2 || byte_count !== 32'd68) begin
            n_fail++; $display("FAIL bp_counters: got %0d/%0d required 2/68", pkt_count, byte_count);
        end
    endtask

    task automatic test_enable_boundary();
        int t0, m;
        @(posedge clk); #1;
        tready = 1'b0; mon_q.delete();
        for (int i = 0; i < 4; i++) push_word(64'hC000_0000_0000_0000 | 64'(i), 8'hFF, i == 3);
        tready = 1'b1;
        t0 = cyc;
        fork
            begin
                push_word(64'hC100_0000_0000_0000, 8'hFF, 1'b0);
                push_word(64'hC100_0000_0000_0001, 8'hFF, 1'b1);
            end
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                tx_enable = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mon_q.size() != 4) begin
            n_fail++; $display("FAIL en_first_pkt: got %0d beats required 4", mon_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (mon_q[i].d !== (64'hC000_0000_0000_0000 | 64'(i)) || mon_q[i].c != t0 + i) begin
                    n_fail++;
                    $display("FAIL en_beat%0d: got d=%h cyc=%0d required d=%h cyc=%0d",
                             i, mon_q[i].d, mon_q[i].c, 64'hC000_0000_0000_0000 | 64'(i), t0 + i);
                end
            end
        end
        n_tests++;
        if (tvalid !== 1'b0 || fifo_level !== 3'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL en_gated: got v=%b lvl=%0d busy=%b required v=0 lvl=2 busy=1", tvalid, fifo_level, busy);
        end
        @(posedge clk); #1;
        tx_enable = 1'b1;
        m = cyc;
        @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b0) begin n_fail++; $display("FAIL en_resume_early: tvalid got %b required 0", tvalid); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mon_q.size() != 6) begin
            n_fail++; $display("FAIL en_second_pkt: got %0d beats required 6", mon_q.size());
        end else begin
            for (int i = 4; i < 6; i++) begin
                n_tests++;
                if (mon_q[i].d !== (64'hC100_0000_0000_0000 | 64'(i - 4)) || mon_q[i].c != m + i - 3) begin
                    n_fail++;
                    $display("FAIL en_resume_beat%0d: got d=%h cyc=%0d required d=%h cyc=%0d",
                             i, mon_q[i].d, mon_q[i].c, 64'hC100_0000_0000_0000 | 64'(i - 4), m + i - 3);
                end
            end
        end
        n_tests++;
        if (pkt_count !== 32'd4 || byte_count !== 32'd116) begin
            n_fail++; $display("FAIL en_counters: got %0d/%0d required 4/116", pkt_count, byte_count);
        end
    endtask

    task automatic test_keep_errors();
        @(posedge clk); #1;
        mon_q.delete();
        push_word(64'hD000_0000_0000_0000, 8'h7F, 1'b0);
        push_word(64'hD000_0000_0000_0001, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (keep_err_count !== 16'd2) begin n_fail++; $display("FAIL keep_err: got %0d required 2", keep_err_count); end
        n_tests++;
        if (mon_q.size() != 2 || mon_q[0].k !== 8'h7F || mon_q[1].k !== 8'h00 || mon_q[1].d !== 64'hD000_0000_0000_0001) begin
            n_fail++; $display("FAIL keep_forward: got %0d beats, keeps not 7f/00 as required", mon_q.size());
        end
        n_tests++;
        if (pkt_count !== 32'd5 || byte_count !== 32'd123) begin
            n_fail++; $display("FAIL keep_counters: got %0d/%0d required 5/123", pkt_count, byte_count);
        end
        @(posedge clk); #1;
        push_word(64'hD000_0000_0000_0002, 8'hFF, 1'b1);
        cnt_clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b1 || tready !== 1'b1) begin n_fail++; $display("FAIL clr_pop_cycle: tvalid got %b required 1", tvalid); end
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pkt_count !== 32'd0 || byte_count !== 32'd0 || keep_err_count !== 16'd0 || mon_q.size() != 3) begin
            n_fail++;
            $display("FAIL clr_priority: got %0d/%0d/%0d beats=%0d required 0/0/0 beats=3",
                     pkt_count, byte_count, keep_err_count, mon_q.size());
        end
    endtask

    task automatic test_stability();
        int exp_bytes;
        @(posedge clk); #1;
        mon_q.delete(); exp_q.delete();
        exp_bytes = 0; prod_done = 0; stab_en = 1;
        fork
            begin
                for (int p = 0; p < 50; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int w = 0; w < len; w++) begin
                        logic [63:0] d;
                        logic [7:0]  k;
                        d = {$urandom, $urandom};
                        k = (w == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
                        exp_q.push_back('{d: d, k: k, l: (w == len - 1), c: 0});
                        exp_bytes += $countones(k);
                        push_word(d, k, w == len - 1);
                    end
                end
                prod_done = 1;
            end
            begin
                int n;
                n = 0;
                while (!(prod_done && mon_q.size() == exp_q.size()) && n < 5000) begin
                    tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    n++;
                end
                tready = 1'b1;
            end
        join
        stab_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mon_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stab_beats: got %0d beats required %0d", mon_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (mon_q[i].d !== exp_q[i].d || mon_q[i].k !== exp_q[i].k || mon_q[i].l !== exp_q[i].l) begin
                    n_fail++;
                    $display("FAIL stab_beat%0d: got d=%h k=%h l=%b required d=%h k=%h l=%b",
                             i, mon_q[i].d, mon_q[i].k, mon_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
                end
            end
        end
        n_tests++;
        if (byte_count !== 32'(exp_bytes) || pkt_count !== 32'd50 || keep_err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stab_counters: got %0d/%0d/%0d required 50/%0d/0", pkt_count, byte_count, keep_err_count, exp_bytes);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        @(posedge clk); #1;
        tready = 1'b0; mon_q.delete();
        push_word(64'hE000_0000_0000_0000, 8'hFF, 1'b0);
        push_word(64'hE000_0000_0000_0001, 8'hFF, 1'b0);
        push_word(64'hE000_0000_0000_0002, 8'hFF, 1'b0);
        tready = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b required 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tvalid !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0 || tdata !== 64'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state: got v=%b lvl=%0d busy=%b d=%h rdy=%b required v=0 lvl=0 busy=0 d=0 rdy=1",
                     tvalid, fifo_level, busy, tdata, in_ready);
        end
        n_tests++;
        if (pkt_count !== 32'd0 || byte_count !== 32'd0 || keep_err_count !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_counters: got %0d/%0d/%0d required 0/0/0", pkt_count, byte_count, keep_err_count);
        end
        @(posedge clk); #1;
        tready = 1'b1;
        push_word(64'hE100_0000_0000_0000, 8'h03, 1'b1);
        n0 = push_cyc;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mon_q.size() != 2 || mon_q[1].d !== 64'hE100_0000_0000_0000 || mon_q[1].c != n0 + 2) begin
            n_fail++; $display("FAIL rstmid_restart: got beats=%0d required 2 with new word at cyc %0d", mon_q.size(), n0 + 2);
        end
        n_tests++;
        if (pkt_count !== 32'd1 || byte_count !== 32'd2) begin
            n_fail++; $display("FAIL rstmid_after: got %0d/%0d required 1/2", pkt_count, byte_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_backpressure();
        test_enable_boundary();
        test_keep_errors();
        test_stability();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
